mem_wb_stage: RTL and testbench

- Parametrised, elastic MEM/WB pipeline register for the 8-bit core.
- Carries opcode, destination/source register addresses, ALU result and RAM read data from the MEM stage to write-back.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, bubble (NOP) injection, a registered write-back data select and a saturating stall counter.
- Sits between the EX/MEM register plus RAM read port and the register-file write port and forwarding unit.

---
 rtl/mem_wb_stage.sv | 118 +++++++++++
 tb/tb_mem_wb_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB pipeline register: a main entry plus a 2nd skid entry behind a
// registered valid/ready handshake. It also provides flush, bubble outputs, write-back data select and a stall counter.
module mem_wb_stage #(
  parameter int                  OPCODE_W    = 5,
  parameter int                  RD_W        = 3,
  parameter int                  RS_W        = 4,
  parameter int                  DATA_W      = 8,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE  = 5'h1f,
  parameter logic [OPCODE_W-1:0] LOAD_OPCODE = 5'h04,
  parameter int                  STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [RD_W-1:0]        in_rd_addr,
  input  logic [RS_W-1:0]        in_r1_addr,
  input  logic [RS_W-1:0]        in_r2_addr,
  input  logic [DATA_W-1:0]      in_alu_out,
  input  logic [DATA_W-1:0]      in_r_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPCODE_W-1:0]    out_opcode,
  output logic [RD_W-1:0]        out_rd_addr,
  output logic [RS_W-1:0]        out_r1_addr,
  output logic [RS_W-1:0]        out_r2_addr,
  output logic [DATA_W-1:0]      out_alu_out,
  output logic [DATA_W-1:0]      out_r_data,
  output logic [DATA_W-1:0]      out_wb_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [RD_W-1:0]     rd_addr;
    logic [RS_W-1:0]     r1_addr;
    logic [RS_W-1:0]     r2_addr;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   wb_data;
  } entry_t;

  function automatic entry_t bubble_entry();
    entry_t e;
    e        = '0;
    e.opcode = NOP_OPCODE;
    return e;
  endfunction

  entry_t m_q, s_q, in_entry;
  logic   m_valid, s_valid;
  logic   accept, drain;

  // Write-back select is resolved from the entry's own opcode as it is captured.
  always_comb begin
    // NOTE: default the whole struct first so no field can infer a latch.
    in_entry         = '0;
    in_entry.opcode  = in_opcode;
    in_entry.rd_addr = in_rd_addr;
    in_entry.r1_addr = in_r1_addr;
    in_entry.r2_addr = in_r2_addr;
    in_entry.alu_out = in_alu_out;
    in_entry.r_data  = in_r_data;
    in_entry.wb_data = (in_opcode == LOAD_OPCODE) ? in_r_data : in_alu_out;
  end

  assign in_ready = !s_valid;
  assign accept   = in_valid && !s_valid;
  assign drain    = m_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      m_valid <= 1'b0;
      m_q     <= bubble_entry();
      s_valid <= 1'b0;
    end else if (!m_valid || drain) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_q     <= in_entry;
      end else begin
        m_valid <= 1'b0;
        m_q     <= bubble_entry();
      end
    end else if (accept) begin
      s_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is not reset; s_valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (accept) s_q <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_valid   = m_valid;
  assign out_opcode  = m_q.opcode;
  assign out_rd_addr = m_q.rd_addr;
  assign out_r1_addr = m_q.r1_addr;
  assign out_r2_addr = m_q.r2_addr;
  assign out_alu_out = m_q.alu_out;
  assign out_r_data  = m_q.r_data;
  assign out_wb_data = m_q.wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a FIFO scoreboard model of the stage contents.
// A second instance with a 4-bit stall counter exercises saturation.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [7:0] alu;
    logic [7:0] rdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [4:0] in_opcode;
  logic [2:0] in_rd_addr;
  logic [3:0] in_r1_addr, in_r2_addr;
  logic [7:0] in_alu_out, in_r_data;

  logic        in_ready, out_valid;
  logic [4:0]  out_opcode;
  logic [2:0]  out_rd_addr;
  logic [3:0]  out_r1_addr, out_r2_addr;
  logic [7:0]  out_alu_out, out_r_data, out_wb_data;
  logic [15:0] stall_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [4:0]  sat_out_opcode;
  logic [2:0]  sat_out_rd_addr;
  logic [3:0]  sat_out_r1_addr, sat_out_r2_addr;
  logic [7:0]  sat_out_alu_out, sat_out_r_data, sat_out_wb_data;
  logic [3:0]  sat_stall_cnt;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd_addr(in_rd_addr), .in_r1_addr(in_r1_addr),
    .in_r2_addr(in_r2_addr), .in_alu_out(in_alu_out), .in_r_data(in_r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd_addr(out_rd_addr), .out_r1_addr(out_r1_addr), .out_r2_addr(out_r2_addr),
    .out_alu_out(out_alu_out), .out_r_data(out_r_data), .out_wb_data(out_wb_data),
    .stall_cnt(stall_cnt)
  );

  mem_wb_stage #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_opcode(in_opcode), .in_rd_addr(in_rd_addr), .in_r1_addr(in_r1_addr),
    .in_r2_addr(in_r2_addr), .in_alu_out(in_alu_out), .in_r_data(in_r_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_opcode(sat_out_opcode),
    .out_rd_addr(sat_out_rd_addr), .out_r1_addr(sat_out_r1_addr),
    .out_r2_addr(sat_out_r2_addr), .out_alu_out(sat_out_alu_out),
    .out_r_data(sat_out_r_data), .out_wb_data(sat_out_wb_data),
    .stall_cnt(sat_stall_cnt)
  );

  always #5 clk = ~clk;

  txn_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   stalls = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [4:0] op, input logic [7:0] alu,
                              input logic [7:0] rdata);
    txn_t t;
    t.op    = op;
    t.rd    = alu[2:0];
    t.r1    = alu[3:0] ^ 4'h5;
    t.r2    = alu[7:4];
    t.alu   = alu;
    t.rdata = rdata;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    in_valid   = 1'b1;
    in_opcode  = t.op;
    in_rd_addr = t.rd;
    in_r1_addr = t.r1;
    in_r2_addr = t.r2;
    in_alu_out = t.alu;
    in_r_data  = t.rdata;
  endtask

  // Idle cycles carry garbage payload that must never reach the output.
  task automatic idle();
    in_valid   = 1'b0;
    in_opcode  = 5'($urandom);
    in_rd_addr = 3'($urandom);
    in_r1_addr = 4'($urandom);
    in_r2_addr = 4'($urandom);
    in_alu_out = 8'($urandom);
    in_r_data  = 8'($urandom);
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic cycle(input string tag);
    txn_t       cur, exp;
    bit         acc, drn, stall;
    logic [7:0] wb;
    chk(tag, "in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
    chk(tag, "out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
    if (sb.size() > 0) begin
      exp = sb[0];
      wb  = (exp.op == 5'h04) ? exp.rdata : exp.alu;
    end else begin
      exp    = '0;
      exp.op = 5'h1f;
      wb     = 8'h00;
    end
    chk(tag, "opcode", {27'd0, out_opcode}, {27'd0, exp.op});
    chk(tag, "rd_addr", {29'd0, out_rd_addr}, {29'd0, exp.rd});
    chk(tag, "r1_addr", {28'd0, out_r1_addr}, {28'd0, exp.r1});
    chk(tag, "r2_addr", {28'd0, out_r2_addr}, {28'd0, exp.r2});
    chk(tag, "alu_out", {24'd0, out_alu_out}, {24'd0, exp.alu});
    chk(tag, "r_data", {24'd0, out_r_data}, {24'd0, exp.rdata});
    chk(tag, "wb_data", {24'd0, out_wb_data}, {24'd0, wb});
    chk(tag, "stall_cnt", {16'd0, stall_cnt}, stalls);
    chk(tag, "sat_stall_cnt", {28'd0, sat_stall_cnt}, (stalls > 15) ? 15 : stalls);

    cur   = '{op: in_opcode, rd: in_rd_addr, r1: in_r1_addr, r2: in_r2_addr,
              alu: in_alu_out, rdata: in_r_data};
    acc   = in_valid && (sb.size() < 2);
    drn   = (sb.size() > 0) && out_ready;
    stall = (sb.size() > 0) && !out_ready;
    if (rst) begin
      sb.delete();
      stalls = 0;
    end else begin
      if (stall) stalls++;
      if (flush) sb.delete();
      else begin
        if (drn) void'(sb.pop_front());
        if (acc) sb.push_back(cur);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle with garbage inputs.
    repeat (3) cycle("reset_idle");

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 4; i++) begin
      drive(mk(5'h01, 8'h10 + 8'(i), 8'h80 + 8'(i)));
      cycle("stream");
    end
    idle();
    repeat (2) cycle("stream_tail");

    // Backpressure: two accepted, third held, long stall saturates the narrow counter.
    out_ready = 1'b0;
    drive(mk(5'h02, 8'h21, 8'h31));
    cycle("stall_a");
    drive(mk(5'h04, 8'h22, 8'h32));
    cycle("stall_b");
    drive(mk(5'h03, 8'h23, 8'h33));
    repeat (20) cycle("stall_hold");
    out_ready = 1'b1;
    repeat (2) cycle("stall_drain");
    idle();
    repeat (2) cycle("stall_tail");

    // Write-back select for load vs ALU op with identical data.
    drive(mk(5'h04, 8'h3c, 8'ha5));
    cycle("wb_load");
    drive(mk(5'h01, 8'h3c, 8'ha5));
    cycle("wb_alu");
    idle();
    repeat (2) cycle("wb_tail");

    // Flush with both entries full and a new input offered.
    out_ready = 1'b0;
    drive(mk(5'h05, 8'h51, 8'h61));
    cycle("flush_fill0");
    drive(mk(5'h06, 8'h52, 8'h62));
    cycle("flush_fill1");
    drive(mk(5'h07, 8'h53, 8'h63));
    flush = 1'b1;
    cycle("flush_edge");
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (2) cycle("flush_after");

    // Reset mid-stream with flush also high.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(5'h08, 8'h70 + 8'(i), 8'h90 + 8'(i)));
      cycle("pre_rst");
    end
    rst   = 1'b1;
    flush = 1'b1;
    cycle("rst_edge");
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (2) cycle("post_rst");
    drive(mk(5'h01, 8'h99, 8'h11));
    cycle("post_rst_stream");
    idle();
    repeat (2) cycle("post_rst_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
